// File: rtl/cpu_read_responder_if.sv
// CPU read-cycle bus bundle: strobes and address in, read data and enable out.
// The master side is the CPU bus model; the slave side is the read responder.
interface cpu_read_responder_if;
    logic        EN;
    logic        RD;
    logic        RDWR;
    logic [1:0]  BRAM_SELECT;
    logic [13:0] ADDR;
    logic [15:0] DATA_OUT;
    logic        DATA_OE;

    modport master (
        output EN,
        output RD,
        output RDWR,
        output BRAM_SELECT,
        output ADDR,
        input  DATA_OUT,
        input  DATA_OE
    );

    modport slave (
        input  EN,
        input  RD,
        input  RDWR,
        input  BRAM_SELECT,
        input  ADDR,
        output DATA_OUT,
        output DATA_OE
    );
endinterface

// File: rtl/cpu_read_responder.sv
// CPU-bus read responder for the controller register space (CPU_CKIO domain).
// Optional macro CPU_READ_SYS_TIME_SNAPSHOT_EN: coherent 64-bit system-time reads.
module cpu_read_responder #(
    parameter logic [15:0] VERSION    = 16'h0010,
    parameter int          SYS_TIME_W = 64
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    cpu_read_responder_if.slave   bus,
    input  logic [SYS_TIME_W-1:0] SYS_TIME,
    input  logic                  THERMO,
    input  logic [15:0]           CTRL_FLAG,
    input  logic [15:0]           MOD_ADDR_OFFSET
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        rs;
    logic        rs_q;
    logic        start;
    logic        latch;
    logic        load;
    logic        clear;
    logic [1:0]  bsel_q;
    logic [13:0] addr_q;
    logic [15:0] dout_q;
    logic        oe_q;
    logic [15:0] cnt_q;
    logic        thermo_meta;
    logic        thermo_s;
    logic [15:0] rd_data;
    logic [63:0] st;

    assign st    = 64'(SYS_TIME);
    assign rs    = bus.EN & bus.RD & bus.RDWR;
    // rs_q resets high so a strobe still asserted across reset is not a new read
    assign start = rs & ~rs_q;

    assign bus.DATA_OUT = dout_q;
    assign bus.DATA_OE  = oe_q;

`ifdef CPU_READ_SYS_TIME_SNAPSHOT_EN
    // Word 0 is always served live, so only the upper three words are kept
    logic [47:0] snap_hi_q;
    logic        snap_hit;

    assign snap_hit = (bsel_q == 2'h0) && (addr_q == 14'h0002);
`endif

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        load    = 1'b0;
        clear   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DECODE;
                    latch   = 1'b1;
                end
            end
            DECODE: begin
                if (rs) begin
                    state_d = HOLD;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (!rs) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_data = 16'h0000;
        if (bsel_q == 2'h0) begin
            case (addr_q)
                14'h0000: rd_data = CTRL_FLAG;
                14'h0001: rd_data = {15'b0, thermo_s};
                14'h0002: rd_data = st[15:0];
`ifdef CPU_READ_SYS_TIME_SNAPSHOT_EN
                14'h0003: rd_data = snap_hi_q[15:0];
                14'h0004: rd_data = snap_hi_q[31:16];
                14'h0005: rd_data = snap_hi_q[47:32];
`else
                14'h0003: rd_data = st[31:16];
                14'h0004: rd_data = st[47:32];
                14'h0005: rd_data = st[63:48];
`endif
                14'h0006: rd_data = MOD_ADDR_OFFSET;
                14'h0007: rd_data = cnt_q;
                14'h003F: rd_data = VERSION;
                default:  rd_data = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            rs_q        <= 1'b1;
            bsel_q      <= 2'h0;
            addr_q      <= 14'h0000;
            dout_q      <= 16'h0000;
            oe_q        <= 1'b0;
            cnt_q       <= 16'h0000;
            thermo_meta <= 1'b0;
            thermo_s    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rs_q        <= rs;
            thermo_meta <= THERMO;
            thermo_s    <= thermo_meta;
            if (latch) begin
                bsel_q <= bus.BRAM_SELECT;
                addr_q <= bus.ADDR;
            end
            if (load) begin
                dout_q <= rd_data;
                oe_q   <= 1'b1;
                cnt_q  <= cnt_q + 16'd1;
            end else if (clear) begin
                dout_q <= 16'h0000;
                oe_q   <= 1'b0;
            end
        end
    end

`ifdef CPU_READ_SYS_TIME_SNAPSHOT_EN
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            snap_hi_q <= 48'h0;
        end else if (load && snap_hit) begin
            snap_hi_q <= st[63:16];
        end
    end
`endif

endmodule

// File: tb/tb_cpu_read_responder.sv
// Self-checking bench for cpu_read_responder: vector table, corner sequences
// and randomized reads against a register-map reference model.
module tb_cpu_read_responder;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [63:0] tick = 64'd0;
    logic [63:0] st_off = 64'd0;
    logic [63:0] SYS_TIME;
    logic        THERMO = 1'b0;
    logic [15:0] CTRL_FLAG = 16'h0;
    logic [15:0] MOD_ADDR_OFFSET = 16'h0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) tick <= tick + 64'd1;
    assign SYS_TIME = tick + st_off;

    cpu_read_responder_if bus();

    cpu_read_responder dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .bus            (bus.slave),
        .SYS_TIME       (SYS_TIME),
        .THERMO         (THERMO),
        .CTRL_FLAG      (CTRL_FLAG),
        .MOD_ADDR_OFFSET(MOD_ADDR_OFFSET)
    );

    int          total = 0;
    int          bad = 0;
    logic [15:0] m_cnt = 16'h0;
    logic [63:0] m_snap = 64'h0;

    typedef struct {
        logic [1:0]  bs;
        logic [13:0] a;
        logic [15:0] ctrl;
        logic [15:0] mod;
        int          hold;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // Register map from the read-side description, not from the RTL mux
    function automatic logic [15:0] model(input logic [1:0] bs,
                                          input logic [13:0] a,
                                          input logic [63:0] live);
        logic [63:0] src;
        int          sh;
        if (bs != 2'h0) return 16'h0;
        if (a == 14'h0) return CTRL_FLAG;
        if (a == 14'h1) return {15'b0, THERMO};
        if (a >= 14'h2 && a <= 14'h5) begin
            src = live;
`ifdef CPU_READ_SYS_TIME_SNAPSHOT_EN
            if (a != 14'h2) src = m_snap;
`endif
            sh = 16 * (int'(a) - 2);
            return 16'(src >> sh);
        end
        if (a == 14'h6) return MOD_ADDR_OFFSET;
        if (a == 14'h7) return m_cnt;
        if (a == 14'h3F) return 16'h0010;
        return 16'h0;
    endfunction

    task automatic rs_set(input logic v);
        bus.EN   = v;
        bus.RD   = v;
        bus.RDWR = v;
    endtask

    task automatic rs_drop();
        case ($urandom_range(0, 2))
            0: bus.EN = 1'b0;
            1: bus.RD = 1'b0;
            default: bus.RDWR = 1'b0;
        endcase
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    // Called at a negedge; returns at a negedge with rs low for one cycle
    task automatic do_read(input logic [1:0] bs, input logic [13:0] a,
                           input int hold, input logic chg,
                           input logic use_exp, input logic [15:0] exp_in,
                           input string nm);
        logic [15:0] exp;
        logic [63:0] live;
        bus.BRAM_SELECT = bs;
        bus.ADDR        = a;
        rs_set(1'b1);
        cyc(1);
        chk({nm, "/lat"}, 64'(bus.DATA_OE), 64'd0);
        live = SYS_TIME;
        exp  = use_exp ? exp_in : model(bs, a, live);
        if (chg) begin
            bus.ADDR        = ~a;
            bus.BRAM_SELECT = ~bs;
        end
        cyc(1);
        chk({nm, "/data"}, 64'({bus.DATA_OE, bus.DATA_OUT}), 64'({1'b1, exp}));
        if (bs == 2'h0 && a == 14'h2) m_snap = live;
        m_cnt = m_cnt + 16'd1;
        for (int i = 2; i < hold; i++) begin
            if (chg) bus.ADDR = 14'h6;
            cyc(1);
            chk({nm, "/hold"}, 64'({bus.DATA_OE, bus.DATA_OUT}), 64'({1'b1, exp}));
        end
        rs_drop();
        cyc(1);
        chk({nm, "/end"}, 64'({bus.DATA_OE, bus.DATA_OUT}), 64'd0);
    endtask

    task automatic do_abort(input logic [1:0] bs, input logic [13:0] a,
                            input string nm);
        bus.BRAM_SELECT = bs;
        bus.ADDR        = a;
        rs_set(1'b1);
        cyc(1);
        rs_drop();
        chk({nm, "/dec"}, 64'(bus.DATA_OE), 64'd0);
        cyc(1);
        chk({nm, "/after"}, 64'({bus.DATA_OE, bus.DATA_OUT}), 64'd0);
        cyc(1);
        chk({nm, "/late"}, 64'({bus.DATA_OE, bus.DATA_OUT}), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1);
    end

    initial begin
        logic [1:0]  bs;
        logic [13:0] a;
        int          k;

        tbl[0] = '{2'h0, 14'h003F, 16'h0000, 16'h0000, 3, 16'h0010};
        tbl[1] = '{2'h0, 14'h0007, 16'h0000, 16'h0000, 2, 16'h0001};
        tbl[2] = '{2'h0, 14'h0000, 16'h1234, 16'h0000, 2, 16'h1234};
        tbl[3] = '{2'h0, 14'h0006, 16'h0000, 16'hBEEF, 4, 16'hBEEF};
        tbl[4] = '{2'h1, 14'h0000, 16'hFFFF, 16'h0000, 2, 16'h0000};
        tbl[5] = '{2'h0, 14'h0008, 16'hFFFF, 16'hFFFF, 2, 16'h0000};
        tbl[6] = '{2'h0, 14'h003E, 16'h0000, 16'h0000, 3, 16'h0000};
        tbl[7] = '{2'h3, 14'h003F, 16'h0000, 16'h0000, 2, 16'h0000};
        tbl[8] = '{2'h0, 14'h0007, 16'h0000, 16'h0000, 2, 16'h0008};
        tbl[9] = '{2'h0, 14'h0001, 16'hFFFF, 16'h0000, 2, 16'h0000};

        rs_set(1'b0);
        bus.BRAM_SELECT = 2'h0;
        bus.ADDR        = 14'h0;
        @(negedge CLK);
        cyc(2);
        chk("reset_state", 64'({bus.DATA_OE, bus.DATA_OUT}), 64'd0);
        RESET_N = 1'b1;
        cyc(1);

        foreach (tbl[i]) begin
            CTRL_FLAG       = tbl[i].ctrl;
            MOD_ADDR_OFFSET = tbl[i].mod;
            do_read(tbl[i].bs, tbl[i].a, tbl[i].hold, 1'b0, 1'b1,
                    tbl[i].exp, $sformatf("tbl%0d", i));
        end

        CTRL_FLAG = 16'hA5A5;
        do_abort(2'h0, 14'h0000, "abort");
        do_read(2'h0, 14'h0007, 2, 1'b0, 1'b1, 16'd10, "cnt_after_abort");

        bus.ADDR = 14'h003F;
        bus.EN   = 1'b1;
        bus.RD   = 1'b1;
        bus.RDWR = 1'b0;
        cyc(3);
        chk("write_dir", 64'({bus.DATA_OE, bus.DATA_OUT}), 64'd0);
        rs_set(1'b0);
        cyc(1);
        do_read(2'h0, 14'h0007, 2, 1'b0, 1'b1, 16'd11, "cnt_after_wr");

        THERMO = 1'b1;
        cyc(3);
        do_read(2'h0, 14'h0001, 4, 1'b1, 1'b1, 16'h0001, "thermo");

        st_off = 64'h1234_FFFF_FFFF_FFD0 - tick;
        do_read(2'h0, 14'h0002, 2, 1'b0, 1'b0, 16'h0, "st_w0");
        cyc(100);
`ifdef CPU_READ_SYS_TIME_SNAPSHOT_EN
        do_read(2'h0, 14'h0005, 2, 1'b0, 1'b1, 16'h1234, "st_w3");
`else
        do_read(2'h0, 14'h0005, 2, 1'b0, 1'b1, 16'h1235, "st_w3");
`endif
        do_read(2'h0, 14'h0004, 2, 1'b0, 1'b0, 16'h0, "st_w2");
        do_read(2'h0, 14'h0003, 3, 1'b0, 1'b0, 16'h0, "st_w1");

        force dut.cnt_q = 16'hFFFF;
        cyc(1);
        release dut.cnt_q;
        m_cnt = 16'hFFFF;
        cyc(1);
        do_read(2'h0, 14'h0007, 2, 1'b0, 1'b1, 16'hFFFF, "cnt_max");
        do_read(2'h0, 14'h0007, 2, 1'b0, 1'b1, 16'h0000, "cnt_wrap");

        for (int i = 0; i < 300; i++) begin
            if (i % 50 == 49) begin
                THERMO = ~THERMO;
                cyc(3);
            end
            CTRL_FLAG       = 16'($urandom);
            MOD_ADDR_OFFSET = 16'($urandom);
            bs = ($urandom_range(0, 9) < 7) ? 2'h0 : 2'($urandom);
            k  = $urandom_range(0, 10);
            a  = (k < 8) ? 14'(k) : (k == 8) ? 14'h003F : 14'($urandom);
            if ($urandom_range(0, 7) == 0)
                do_abort(bs, a, "rnd_abort");
            else
                do_read(bs, a, $urandom_range(2, 4), 1'($urandom_range(0, 1)),
                        1'b0, 16'h0, "rnd");
            if ($urandom_range(0, 3) == 0) cyc(1);
        end

        bus.BRAM_SELECT = 2'h0;
        bus.ADDR        = 14'h003F;
        rs_set(1'b1);
        cyc(2);
        chk("rst_hold_pre", 64'({bus.DATA_OE, bus.DATA_OUT}), 64'h1_0010);
        RESET_N = 1'b0;
        cyc(1);
        chk("rst_hold", 64'({bus.DATA_OE, bus.DATA_OUT}), 64'd0);
        RESET_N = 1'b1;
        cyc(3);
        chk("rst_rs_high", 64'({bus.DATA_OE, bus.DATA_OUT}), 64'd0);
        rs_set(1'b0);
        m_cnt  = 16'h0;
        m_snap = 64'h0;
        cyc(1);
        do_read(2'h0, 14'h0007, 2, 1'b0, 1'b1, 16'h0000, "cnt_after_rst");
        do_read(2'h0, 14'h0004, 2, 1'b0, 1'b0, 16'h0, "st_after_rst");
        do_read(2'h0, 14'h0007, 2, 1'b0, 1'b1, 16'h0002, "cnt_after_rst2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
